// File: rtl/mac_accumulator.sv
// mac_accumulator
//   Streams signed Q8.8 operand pairs, forms a rounded Q8.8 product per beat
//   and accumulates the products into a wide accumulator. When a vector closes,
//   either on i_last or after MAX_LEN beats, the sum is clipped to 16-bit Q8.8
//   and held on the output until downstream takes it.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst      : asynchronous active-high reset
//   i_valid  : operand pair valid
//   i_a      : signed Q8.8 multiplicand
//   i_b      : signed Q8.8 multiplier
//   i_last   : final beat of the current vector
//   o_ready  : block accepts a beat this cycle (IDLE/ACCUM only)
//   o_valid  : o_result holds a finished dot product
//   o_result : saturated signed Q8.8 dot product
//   o_sat    : o_result was clipped
//   o_trunc  : vector was forced closed at MAX_LEN beats
//   i_ready  : downstream accepts o_result (only meaningful in DONE)
module mac_accumulator #(
  parameter int MAX_LEN = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic signed [15:0] i_a,
  input  logic signed [15:0] i_b,
  input  logic               i_last,
  output logic               o_ready,
  output logic               o_valid,
  output logic signed [15:0] o_result,
  output logic               o_sat,
  output logic               o_trunc,
  input  logic               i_ready
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [9:0] LAST_IDX = 10'(MAX_LEN - 1);

  // (p + 0.5 LSB) >>> 8 : rounds half toward +inf
  function automatic logic signed [23:0] round_q8(input logic signed [31:0] p);
    logic signed [31:0] s;
    s = (p + 32'sd128) >>> 8;
    return 24'(s);
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)
      return 16'sh7fff;
    else if (v < -32'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  function automatic logic is_clipped(input logic signed [31:0] v);
    return (v > 32'sd32767) || (v < -32'sd32768);
  endfunction

  logic [1:0]  state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        drain_q, drain_d;
  logic        trunc_q, trunc_d;

  logic               accept;
  logic               beat_last;
  logic signed [31:0] prod_p0;

  logic signed [23:0] term_p1_q;
  logic               vld_p1_q;
  logic               first_p1_q;
  logic signed [31:0] acc_p2_q;

  assign o_ready   = ~rst && ((state_q == ST_IDLE) || (state_q == ST_ACCUM));
  assign accept    = i_valid && o_ready;
  // The MAX_LEN-th beat closes the vector even without i_last
  assign beat_last = i_last || (cnt_q == LAST_IDX);
  assign prod_p0   = $signed({{16{i_a[15]}}, i_a}) * $signed({{16{i_b[15]}}, i_b});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    trunc_d = trunc_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          cnt_d   = cnt_q + 10'd1;
          drain_d = 1'b0;
          trunc_d = !i_last && (cnt_q == LAST_IDX);
          state_d = beat_last ? ST_DRAIN : ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        // Two cycles: one for the accumulate, one to register the outputs
        drain_d = ~drain_q;
        if (drain_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
          cnt_d   = 10'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 10'd0;
      drain_q <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      trunc_q <= trunc_d;
    end
  end

  // Stage p1: rounded product registered at the accept edge
  // Stage p2: accumulator, loads on the first beat of a vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      term_p1_q  <= '0;
      vld_p1_q   <= 1'b0;
      first_p1_q <= 1'b0;
      acc_p2_q   <= '0;
    end else begin
      vld_p1_q <= accept;
      if (accept) begin
        term_p1_q  <= round_q8(prod_p0);
        first_p1_q <= (cnt_q == 10'd0);
      end
      if (vld_p1_q)
        acc_p2_q <= first_p1_q ? 32'(term_p1_q) : acc_p2_q + 32'(term_p1_q);
    end
  end

  // Output stage: loaded on the second drain cycle, held through DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_sat    <= 1'b0;
      o_trunc  <= 1'b0;
    end else if ((state_q == ST_DRAIN) && drain_q) begin
      o_valid  <= 1'b1;
      o_result <= sat16(acc_p2_q);
      o_sat    <= is_clipped(acc_p2_q);
      o_trunc  <= trunc_q;
    end else if ((state_q == ST_DONE) && i_ready) begin
      o_valid  <= 1'b0;
    end
  end

endmodule
